// File: rtl/class_pkg.sv
// Shared types and defaults for the per-entry reuse classification counters.
package class_pkg;

  typedef enum logic [1:0] {
    AGE_IDLE,
    AGE_SWEEP,
    AGE_DONE
  } age_state_t;

  localparam int unsigned DefNumEntries = 32;
  localparam int unsigned DefCtrW       = 2;
  localparam int unsigned DefThresh     = 1;
  localparam int unsigned DefAgePeriod  = 1024;

  function automatic int unsigned ctr_max(input int unsigned ctr_w);
    return (32'd1 << ctr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/class_sat_ctr.sv
// One saturating reuse counter: clear beats increment beats halve.
module class_sat_ctr
  import class_pkg::*;
#(
  parameter int unsigned CTR_W  = DefCtrW,
  parameter int unsigned THRESH = DefThresh
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             halve,
  output logic [CTR_W-1:0] value,
  output logic             class_bit
);

  localparam logic [CTR_W-1:0] CtrMax    = CTR_W'(ctr_max(CTR_W));
  localparam logic [CTR_W-1:0] ThreshVal = CTR_W'(THRESH);

  logic [CTR_W-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (clr) begin
      ctr_d = '0;
    end else if (inc) begin
      // Check saturation before adding so the counter never wraps.
      ctr_d = (ctr_q == CtrMax) ? ctr_q : ctr_q + CTR_W'(1);
    end else if (halve) begin
      ctr_d = ctr_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign value     = ctr_q;
  assign class_bit = (ctr_q >= ThreshVal);

endmodule

// File: rtl/class_ctr_array.sv
// Array of saturating reuse counters with periodic aging sweeps.
// Optional hit/promotion statistics are compiled in with CLASS_STATS_EN.
module class_ctr_array
  import class_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = DefNumEntries,
  parameter int unsigned ADDR_W      = $clog2(NUM_ENTRIES),
  parameter int unsigned CTR_W       = DefCtrW,
  parameter int unsigned THRESH      = DefThresh,
  parameter int unsigned AGE_PERIOD  = DefAgePeriod
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      write_addr,
  input  logic                   re,
  input  logic                   hit,
  input  logic [ADDR_W-1:0]      access_addr,
  input  logic                   age_req,
  output logic [NUM_ENTRIES-1:0] class_vec,
  input  logic [ADDR_W-1:0]      query_addr,
  output logic [CTR_W-1:0]       query_ctr,
  output logic                   age_busy,
  output logic                   age_done,
  output logic [31:0]            stat_hits,
  output logic [31:0]            stat_promotes
);

  localparam logic [ADDR_W-1:0] LastPtr    = ADDR_W'(NUM_ENTRIES - 1);
  localparam logic [31:0]       PeriodLast = 32'(AGE_PERIOD - 1);

  age_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       period_q, period_d;
  logic              trigger;
  logic [CTR_W-1:0]  ctr_val [NUM_ENTRIES];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    period_d = period_q;
    age_busy = 1'b0;
    age_done = 1'b0;
    trigger  = 1'b0;
    unique case (state_q)
      AGE_IDLE: begin
        trigger = age_req || ((AGE_PERIOD != 0) && (period_q == PeriodLast));
        if (trigger) begin
          state_d  = AGE_SWEEP;
          ptr_d    = '0;
          period_d = '0;
        end else begin
          period_d = period_q + 32'd1;
        end
      end
      AGE_SWEEP: begin
        age_busy = 1'b1;
        period_d = '0;
        ptr_d    = ptr_q + ADDR_W'(1);
        if (ptr_q == LastPtr) begin
          state_d = AGE_DONE;
        end
      end
      AGE_DONE: begin
        age_done = 1'b1;
        period_d = '0;
        state_d  = AGE_IDLE;
      end
      default: state_d = AGE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= AGE_IDLE;
      ptr_q    <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      period_q <= period_d;
    end
  end

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cell
    logic clr, inc, halve;
    assign clr   = we && (write_addr == ADDR_W'(i));
    assign inc   = re && hit && (access_addr == ADDR_W'(i));
    assign halve = age_busy && (ptr_q == ADDR_W'(i));

    class_sat_ctr #(
      .CTR_W (CTR_W),
      .THRESH(THRESH)
    ) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .inc      (inc),
      .halve    (halve),
      .value    (ctr_val[i]),
      .class_bit(class_vec[i])
    );
  end

  assign query_ctr = ctr_val[query_addr];

`ifdef CLASS_STATS_EN
  logic [31:0]            hits_q, promotes_q;
  logic [NUM_ENTRIES-1:0] class_prev_q;
  logic                   hit_counted, promoted;

  // A hit swallowed by a same-entry fill is not a counted hit.
  assign hit_counted = re && hit && !(we && (write_addr == access_addr));
  assign promoted    = |(class_vec & ~class_prev_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q       <= '0;
      promotes_q   <= '0;
      class_prev_q <= '0;
    end else begin
      class_prev_q <= class_vec;
      if (hit_counted && (hits_q != '1)) begin
        hits_q <= hits_q + 32'd1;
      end
      if (promoted && (promotes_q != '1)) begin
        promotes_q <= promotes_q + 32'd1;
      end
    end
  end

  assign stat_hits     = hits_q;
  assign stat_promotes = promotes_q;
`else
  assign stat_hits     = '0;
  assign stat_promotes = '0;
`endif

endmodule
